// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared helpers for the RAM-backed FIFO controller.
// Pointer wrap for non-power-of-2 depths and level-width constant.
package fifo_ram_ctrl_pkg;

    localparam int LVL_EXTRA = 2;

    function automatic int unsigned ptr_inc(
        input int unsigned p,
        input int unsigned depth
    );
        return (p == depth - 1) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry register FIFO used as the prefetch skid buffer.
// Push/pop/count with synchronous reset and flush.
module fifo_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] mem [2];
    logic             wp;
    logic             rp;
    logic             do_pop;

    assign valid  = (cnt != 2'd0);
    assign data   = mem[rp];
    assign do_pop = pop & valid;

    always_ff @(posedge clk) begin
        if (rst | flush) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push)
                wp <= ~wp;
            if (do_pop)
                rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= push_data;
    end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller for an external 1-cycle-latency dual-port RAM.
// Optional watermark/sticky stats under FIFO_RAM_CTRL_STAT_EN.
module fifo_ram_ctrl
    import fifo_ram_ctrl_pkg::*;
#(
    parameter int ADDRBIT = 6,
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [ADDRBIT+LVL_EXTRA-1:0] level,
    output logic                         ram_wren,
    output logic [ADDRBIT-1:0]           ram_wraddress,
    output logic [WIDTH-1:0]             ram_data,
    output logic [ADDRBIT-1:0]           ram_rdaddress,
    input  logic [WIDTH-1:0]             ram_q
`ifdef FIFO_RAM_CTRL_STAT_EN
    ,
    output logic [ADDRBIT+LVL_EXTRA-1:0] peak_level,
    output logic                         ovf_sticky,
    output logic                         unf_sticky
`endif
);

    localparam int LW = ADDRBIT + LVL_EXTRA;
    localparam int CW = ADDRBIT + 1;

    logic [ADDRBIT-1:0] wptr;
    logic [ADDRBIT-1:0] rptr;
    logic [CW-1:0]      ramcnt;
    logic               inflight;
    logic [1:0]         skid_cnt;
    logic [2:0]         occ;
    logic               clr;
    logic               ram_full;
    logic               push;
    logic               pop;
    logic               rd_issue;

    assign clr      = rst | flush;
    assign ram_full = (ramcnt >= CW'(DEPTH));
    assign in_ready = ~ram_full & ~clr;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Slots the skid will need once the pending read lands, net of this pop.
    assign occ      = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rd_issue = (ramcnt != '0) & (occ < 3'd2);

    assign ram_wren      = push;
    assign ram_wraddress = wptr;
    assign ram_data      = in_data;
    assign ram_rdaddress = rptr;

    assign level = LW'(ramcnt) + LW'(inflight) + LW'(skid_cnt);

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            ramcnt   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)
                wptr <= ADDRBIT'(ptr_inc(32'(wptr), DEPTH));
            if (rd_issue)
                rptr <= ADDRBIT'(ptr_inc(32'(rptr), DEPTH));
            ramcnt   <= ramcnt + CW'(push) - CW'(rd_issue);
            inflight <= rd_issue;
        end
    end

    fifo_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (inflight),
        .push_data (ram_q),
        .pop       (pop),
        .valid     (out_valid),
        .data      (out_data),
        .cnt       (skid_cnt)
    );

`ifdef FIFO_RAM_CTRL_STAT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            peak_level <= '0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            if (level > peak_level)
                peak_level <= level;
            if (in_valid & ~in_ready & ram_full)
                ovf_sticky <= 1'b1;
            if (out_ready & ~out_valid)
                unf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Scoreboard bench for fifo_ram_ctrl with a behavioural dual-port RAM.
// Stat checks are compiled in when FIFO_RAM_CTRL_STAT_EN is defined.
module tb_fifo_ram_ctrl;

    localparam int ADDRBIT = 6;
    localparam int DEPTH   = 64;
    localparam int WIDTH   = 8;
    localparam int LW      = ADDRBIT + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready = 1'b0;
    logic [LW-1:0]      level;
    logic               ram_wren;
    logic [ADDRBIT-1:0] ram_wraddress;
    logic [WIDTH-1:0]   ram_data;
    logic [ADDRBIT-1:0] ram_rdaddress;
    logic [WIDTH-1:0]   ram_q;
`ifdef FIFO_RAM_CTRL_STAT_EN
    logic [LW-1:0]      peak_level;
    logic               ovf_sticky;
    logic               unf_sticky;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] expq [$];
    logic [WIDTH-1:0] e;

    always #5 clk = ~clk;

    fifo_ram_ctrl #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .level         (level),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .ram_rdaddress (ram_rdaddress),
        .ram_q         (ram_q)
`ifdef FIFO_RAM_CTRL_STAT_EN
        ,
        .peak_level    (peak_level),
        .ovf_sticky    (ovf_sticky),
        .unf_sticky    (unf_sticky)
`endif
    );

    // RAM: registered read address, unregistered q.
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDRBIT-1:0] rdaddr_q;
    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_wraddress] <= ram_data;
        rdaddr_q <= ram_rdaddress;
    end
    assign ram_q = mem[rdaddr_q];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_extra actual %0h required none", out_data);
            end else begin
                e = expq.pop_front();
                chk("mon_data", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        out_ready = 1'b1;
        while (expq.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(expq.size()), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int gaps;
        int maxlev;
        bit started;

        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_wren", 32'(ram_wren), 0);

        // Single word latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("lat_wren", 32'(ram_wren), 1);
        chk("lat_wraddr", 32'(ram_wraddress), 0);
        chk("lat_wdata", 32'(ram_data), 32'h A5);
        expq.push_back(8'hA5);
        tick();
        in_valid = 1'b0;
        chk("lat_level_n1", 32'(level), 1);
        chk("lat_ov_n1", 32'(out_valid), 0);
        tick();
        chk("lat_ov_n2", 32'(out_valid), 0);
        chk("lat_level_n2", 32'(level), 1);
        tick();
        chk("lat_ov_n3", 32'(out_valid), 1);
        chk("lat_data_n3", 32'(out_data), 32'h A5);
        drain("lat_drain", 5);
        chk("lat_level_end", 32'(level), 0);

        // Continuous streaming
        out_ready = 1'b1;
        gaps = 0;
        maxlev = 0;
        started = 1'b0;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            chk("str_in_ready", 32'(in_ready), 1);
            expq.push_back(8'(i));
            tick();
            if (out_valid)
                started = 1'b1;
            else if (started)
                gaps++;
            if (int'(level) > maxlev)
                maxlev = int'(level);
        end
        in_valid = 1'b0;
        drain("str_drain", 20);
        chk("str_gaps", 32'(gaps), 0);
        chk("str_maxlev_le3", 32'(maxlev <= 3), 1);

        // Fill to full, overfill, then drain
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef FIFO_RAM_CTRL_STAT_EN
        chk("st_ovf_clr0", 32'(ovf_sticky), 0);
        chk("st_unf_clr0", 32'(unf_sticky), 0);
`endif
        for (int i = 0; i < 70; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            chk("full_in_ready", 32'(in_ready), 32'(i < 66));
            if (i < 66)
                expq.push_back(8'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("full_level", 32'(level), 66);
        chk("full_in_ready_hold", 32'(in_ready), 0);
`ifdef FIFO_RAM_CTRL_STAT_EN
        chk("st_ovf", 32'(ovf_sticky), 1);
        chk("st_peak", 32'(peak_level), 66);
`endif
        drain("full_drain", 200);
        chk("full_level_end", 32'(level), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`ifdef FIFO_RAM_CTRL_STAT_EN
        chk("st_unf", 32'(unf_sticky), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_ovf_clr", 32'(ovf_sticky), 0);
        chk("st_unf_clr", 32'(unf_sticky), 0);
        chk("st_peak_clr", 32'(peak_level), 0);
`endif

        // Pointer wrap across rounds
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 50; i++) begin
                in_valid = 1'b1;
                in_data  = 8'(r * 50 + i + 7);
                #1;
                chk("wrap_in_ready", 32'(in_ready), 1);
                expq.push_back(8'(r * 50 + i + 7));
                tick();
            end
            in_valid = 1'b0;
            drain("wrap_drain", 120);
        end

        // Flush with a read in flight and a same-cycle push
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            expq.push_back(8'(8'h50 + i));
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("fl_level_pre", 32'(level), 10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        #1;
        chk("fl_level_inflight", 32'(level), 9);
        chk("fl_in_ready", 32'(in_ready), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        expq.delete();
        chk("fl_level", 32'(level), 0);
        chk("fl_out_valid", 32'(out_valid), 0);
        repeat (3) tick();
        chk("fl_out_valid_late", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        expq.push_back(8'h3C);
        tick();
        in_valid = 1'b0;
        drain("fl_drain", 10);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("fl_level_end", 32'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
